// File: rtl/rr_issue_arb_pkg.sv
// rr_issue_arb_pkg: shared defaults and one-hot to binary encoding for pselect consumers
package rr_issue_arb_pkg;
  localparam int RR_ARB_N_DEF = 8;
  localparam int RR_ARB_W_DEF = 32;
  function automatic logic [7:0] onehot_to_bin(input logic [255:0] oh);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < 256; i++) if (oh[i]) b = b | 8'(i);
    return b;
  endfunction
endpackage

// File: rtl/pselect.sv
// pselect: rotating-priority one-hot select; lane sel wins first, then sel+1 (DIR=0) or sel-1 (DIR=1)
module pselect #(
  parameter int N = 8,
  parameter bit DIR = 1'b0,
  localparam int S = $clog2(N)
) (
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic [S-1:0] sel,
  output logic [N-1:0] gnt
);
  logic [S-1:0] idx;
  logic found;
  always_comb begin
    gnt = '0;
    found = 1'b0;
    idx = sel;
    for (int k = 0; k < N; k++) begin
      idx = DIR ? sel - S'(k) : sel + S'(k);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_issue_arb.sv
// rr_issue_arb: per-lane request buffers, round-robin pick via pselect, registered output slot
module rr_issue_arb import rr_issue_arb_pkg::*; #(
  parameter int N = RR_ARB_N_DEF,
  parameter int W = RR_ARB_W_DEF,
  localparam int S = $clog2(N)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           flush,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic           out_valid,
  output logic [S-1:0]   out_idx,
  output logic [W-1:0]   out_data,
  input  logic           out_ready,
  output logic [31:0]    issue_cnt
);
  logic [N-1:0] pending, gnt;
  logic [W-1:0] lane_buf [N];
  logic [S-1:0] ptr, win;
  logic load, fire;
  pselect #(.N(N), .DIR(1'b0)) u_psel (.en(1'b1), .req(pending), .sel(ptr), .gnt(gnt));
  assign win = S'(onehot_to_bin(256'(gnt)));
  assign fire = out_valid & out_ready;
  assign load = |pending & (~out_valid | out_ready);
  assign req_ready = ~pending;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      ptr <= '0;
      out_valid <= 1'b0;
      out_idx <= '0;
      out_data <= '0;
      issue_cnt <= '0;
      for (int i = 0; i < N; i++) lane_buf[i] <= '0;
    end else begin
      if (fire) issue_cnt <= issue_cnt + 32'd1;
      if (flush) begin
        pending <= '0;
        out_valid <= 1'b0;
      end else begin
        for (int i = 0; i < N; i++)
          if (req_valid[i] && !pending[i]) begin
            pending[i] <= 1'b1;
            lane_buf[i] <= req_data[i*W +: W];
          end
        // the winner is always pending, so it never collides with a capture above
        if (load) begin
          out_valid <= 1'b1;
          out_idx <= win;
          out_data <= lane_buf[win];
          pending[win] <= 1'b0;
          ptr <= win + S'(1);
        end else if (fire) out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rr_issue_arb.sv
// tb_rr_issue_arb: directed scenarios with a scoreboard queue checked by an output monitor
module tb_rr_issue_arb;
  typedef struct packed {logic [1:0] idx; logic [7:0] data;} exp_t;
  logic clock = 1'b0, reset = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [3:0] req_valid = 4'hf, req_ready, cap;
  logic [31:0] req_data = '0, issue_cnt, c0;
  logic out_valid;
  logic [1:0] out_idx;
  logic [7:0] out_data;
  exp_t sb[$];
  exp_t e;
  int checks = 0, passes = 0;
  rr_issue_arb #(.N(4), .W(8)) dut (
    .clock(clock), .reset(reset), .flush(flush), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data),
    .out_ready(out_ready), .issue_cnt(issue_cnt));
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic push(input logic [1:0] i, input logic [7:0] d);
    sb.push_back('{idx: i, data: d});
  endtask
  task automatic do_reset();
    reset = 1'b0; req_valid = '0; out_ready = 1'b0; flush = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask
  always @(negedge clock)
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_issue: got idx %0d data %0h expected none", out_idx, out_data);
      end else begin
        e = sb.pop_front();
        chk("issue_idx", 32'(out_idx), 32'(e.idx));
        chk("issue_data", 32'(out_data), 32'(e.data));
      end
    end
  initial begin
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 32'hf);
    chk("rst_issue_cnt", issue_cnt, 0);
    req_valid = '0; reset = 1'b1;
    tick();
    chk("post_rst_out_valid", 32'(out_valid), 0);
    chk("post_rst_req_ready", 32'(req_ready), 32'hf);
    // single lane
    out_ready = 1'b1; req_valid = 4'b0100; req_data[23:16] = 8'ha5;
    tick();
    req_valid = '0;
    chk("single_req_ready", 32'(req_ready), 32'hb);
    chk("single_latency", 32'(out_valid), 0);
    push(2, 8'ha5);
    tick();
    chk("single_valid", 32'(out_valid), 1);
    chk("single_idx", 32'(out_idx), 2);
    chk("single_data", 32'(out_data), 32'ha5);
    chk("single_refill_ready", 32'(req_ready), 32'hf);
    tick();
    chk("single_drain", 32'(out_valid), 0);
    chk("single_cnt", issue_cnt, 1);
    // fairness with one refill per lane
    do_reset();
    out_ready = 1'b1; req_valid = 4'hf; req_data = 32'h13121110;
    for (int i = 0; i < 4; i++) push(2'(i), 8'h10 + 8'(i));
    for (int i = 0; i < 4; i++) push(2'(i), 8'h20 + 8'(i));
    tick();
    req_data = 32'h23222120;
    for (int c = 0; c < 12; c++) begin
      cap = req_valid & req_ready;
      tick();
      req_valid = req_valid & ~cap;
    end
    chk("fair_cnt", issue_cnt, 8);
    chk("fair_idle", 32'(out_valid), 0);
    // backpressure: prime ptr to 1 with a lane-0 issue
    do_reset();
    out_ready = 1'b1; req_valid = 4'b0001; req_data = 32'h00000055;
    push(0, 8'h55);
    tick(); req_valid = '0; tick(); tick();
    out_ready = 1'b0; req_valid = 4'b1011; req_data = 32'h63003c60;
    tick(); req_valid = '0;
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_idx", 32'(out_idx), 1);
      chk("bp_data", 32'(out_data), 32'h3c);
      chk("bp_req_ready", 32'(req_ready), 32'h6);
    end
    push(1, 8'h3c); push(3, 8'h63); push(0, 8'h60);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("bp_idle", 32'(out_valid), 0);
    chk("bp_cnt", issue_cnt, 4);
    // pointer wrap after lane 3
    out_ready = 1'b0; req_valid = 4'b1000; req_data = 32'h73000000;
    tick(); req_valid = '0;
    tick();
    req_valid = 4'b0101; req_data = 32'h00720070;
    tick(); req_valid = '0;
    push(3, 8'h73); push(0, 8'h70); push(2, 8'h72);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("wrap_idle", 32'(out_valid), 0);
    // flush with a concurrent handshake
    out_ready = 1'b0; req_valid = 4'hf; req_data = 32'h83828180;
    tick(); req_valid = '0;
    tick();
    req_valid = 4'b1000; req_data = 32'h93000000;
    tick(); req_valid = '0;
    chk("pre_flush_ready", 32'(req_ready), 0);
    chk("pre_flush_valid", 32'(out_valid), 1);
    push(3, 8'h83);
    c0 = issue_cnt;
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_req_ready", 32'(req_ready), 32'hf);
    chk("flush_cnt", issue_cnt, c0 + 1);
    req_valid = 4'b1001; req_data = 32'hc30000c0;
    tick(); req_valid = '0;
    push(0, 8'hc0); push(3, 8'hc3);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("post_flush_idle", 32'(out_valid), 0);
    chk("post_flush_cnt", issue_cnt, c0 + 3);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
